// File: rtl/run_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_pkg : shared state encoding, counter types and default constants |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package run_pkg;

  localparam int c_default_load_bytes = 64;
  localparam int c_default_dump_base  = 64;
  localparam int c_default_dump_bytes = 32;
  localparam int c_default_timeout    = 4095;

  localparam int c_idx_w   = 8;
  localparam int c_count_w = 12;

  typedef logic [c_idx_w-1:0]   idx_t;
  typedef logic [c_count_w-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_sequencer : preload DMem, run the core until done or timeout,    |
// |                 then stream a result window back out.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module run_sequencer
  import run_pkg::*;
#(
  parameter int LOAD_BYTES = c_default_load_bytes,
  parameter int DUMP_BASE  = c_default_dump_base,
  parameter int DUMP_BYTES = c_default_dump_bytes,
  parameter int TIMEOUT    = c_default_timeout
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  output logic       dm_own,
  output logic       dm_wen,
  output logic [7:0] dm_addr,
  output logic [7:0] dm_wdat,
  input  logic [7:0] dm_rdat,
  output logic       core_reset,
  input  logic       core_done,
  output logic       dump_valid,
  input  logic       dump_ready,
  output logic [7:0] dump_data,
  output logic       busy,
  output logic       error
);

  localparam idx_t   c_load_last    = idx_t'(LOAD_BYTES - 1);
  localparam idx_t   c_dump_last    = idx_t'(DUMP_BYTES - 1);
  localparam idx_t   c_dump_base    = idx_t'(DUMP_BASE);
  localparam count_t c_timeout_last = count_t'(TIMEOUT - 1);

  run_state_t r_state;
  run_state_t w_state_next;
  idx_t       r_idx;
  count_t     r_count;
  logic       r_error;

  logic w_load_fire;
  logic w_dump_fire;
  logic w_done_seen;
  logic w_timeout;

  assign w_load_fire = (r_state == ST_LOAD) && load_valid;
  assign w_dump_fire = (r_state == ST_DUMP) && dump_ready;
  // Count is zero only on the first RUN cycle, while the core PC leaves reset.
  assign w_done_seen = core_done && (r_count != '0);
  assign w_timeout   = (r_count == c_timeout_last);

  always_ff @(posedge clk) begin : p_state_reg
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin : p_next_state
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_LOAD;
      ST_LOAD: if (w_load_fire && (r_idx == c_load_last)) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_done_seen) begin
          w_state_next = ST_DUMP;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DUMP: if (w_dump_fire && (r_idx == c_dump_last)) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : p_counters
    if (!reset) begin
      r_idx   <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_count <= '0;
          if (w_load_fire) begin
            r_idx <= (r_idx == c_load_last) ? '0 : r_idx + idx_t'(1);
          end
        end
        ST_RUN: begin
          r_count <= r_count + count_t'(1);
          if (w_done_seen) begin
            r_idx <= '0;
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (w_dump_fire) begin
            r_idx <= (r_idx == c_dump_last) ? '0 : r_idx + idx_t'(1);
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  always_comb begin : p_outputs
    busy       = 1'b1;
    dm_own     = 1'b1;
    core_reset = 1'b1;
    load_ready = 1'b0;
    dm_wen     = 1'b0;
    dm_addr    = '0;
    dm_wdat    = '0;
    dump_valid = 1'b0;
    dump_data  = '0;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_LOAD: begin
        load_ready = 1'b1;
        dm_wen     = load_valid;
        dm_addr    = r_idx;
        dm_wdat    = load_data;
      end
      ST_RUN: begin
        dm_own     = 1'b0;
        core_reset = 1'b0;
      end
      ST_DUMP: begin
        // Index only moves on a handshake, so address and data hold during a stall.
        dm_addr    = c_dump_base + r_idx;
        dump_valid = 1'b1;
        dump_data  = dm_rdat;
      end
      default: busy = 1'b0;
    endcase
  end

  assign error = r_error;

endmodule
`default_nettype wire
